// File: rtl/scratch_mem_pkg.sv
// Shared types and sizing for the histogram scratch memory responder.
// Optional write-first forwarding is enabled by SCRATCH_MEM_FWD_EN.
package scratch_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 20;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/scratch_mem_array.sv
// Plain 1W2R synchronous-read storage; contents are never reset.
// Reads see the pre-write contents on an address collision.
module scratch_mem_array
  import scratch_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re0,
  input  logic [ADDR_W-1:0] i_raddr0,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re0) o_rdata0 <= r_mem[i_raddr0];
    if (i_re1) o_rdata1 <= r_mem[i_raddr1];
  end

endmodule

// File: rtl/scratch_mem_responder.sv
// Scratch memory responder: clear sequencer, write mux, read valid pipe.
// Define SCRATCH_MEM_FWD_EN for same-cycle write-to-read forwarding.
module scratch_mem_responder
  import scratch_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scratch_WE,
  input  logic [ADDR_W-1:0] scratch_write_addr,
  input  logic [DATA_W-1:0] scratch_wdata,
  input  logic              scratch_read_en0,
  input  logic [ADDR_W-1:0] scratch_read_addr0,
  input  logic              scratch_read_en1,
  input  logic [ADDR_W-1:0] scratch_read_addr1,
  output logic [DATA_W-1:0] scratch_rdata0,
  output logic [DATA_W-1:0] scratch_rdata1,
  output logic              scratch_rvalid0,
  output logic              scratch_rvalid1,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;

  logic              r_rvalid0, r_rvalid1;
  logic              r_zero0, r_zero1;
  logic              r_fwd0, r_fwd1;
  logic [DATA_W-1:0] r_fdat0, r_fdat1;

  logic              w_idle, w_clr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_fwd0, w_fwd1;
  logic [DATA_W-1:0] w_arr0, w_arr1;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_clr      = (r_state == ST_CLEAR);
  assign w_mem_we   = (w_idle & scratch_WE) | w_clr;
  assign w_mem_addr = w_clr ? r_cnt : scratch_write_addr;
  assign w_mem_data = w_clr ? '0 : scratch_wdata;

`ifdef SCRATCH_MEM_FWD_EN
  assign w_fwd0 = w_idle & scratch_WE &
                  (scratch_read_addr0 == scratch_write_addr);
  assign w_fwd1 = w_idle & scratch_WE &
                  (scratch_read_addr1 == scratch_write_addr);
`else
  assign w_fwd0 = 1'b0;
  assign w_fwd1 = 1'b0;
`endif

  scratch_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .i_clk    (clock),
    .i_we     (w_mem_we),
    .i_waddr  (w_mem_addr),
    .i_wdata  (w_mem_data),
    .i_re0    (scratch_read_en0),
    .i_raddr0 (scratch_read_addr0),
    .i_re1    (scratch_read_en1),
    .i_raddr1 (scratch_read_addr1),
    .o_rdata0 (w_arr0),
    .o_rdata1 (w_arr1)
  );

  // Terminal count is checked before the increment, so no wrap is used.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (clear_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Zero flags reset high so rdata reads 0 before the array is touched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_zero0   <= 1'b1;
      r_zero1   <= 1'b1;
      r_fwd0    <= 1'b0;
      r_fwd1    <= 1'b0;
      r_fdat0   <= '0;
      r_fdat1   <= '0;
    end else begin
      r_rvalid0 <= scratch_read_en0;
      r_rvalid1 <= scratch_read_en1;
      if (scratch_read_en0) begin
        r_zero0 <= w_clr;
        r_fwd0  <= w_fwd0;
        r_fdat0 <= scratch_wdata;
      end
      if (scratch_read_en1) begin
        r_zero1 <= w_clr;
        r_fwd1  <= w_fwd1;
        r_fdat1 <= scratch_wdata;
      end
    end
  end

  assign scratch_rdata0  = r_zero0 ? '0 : (r_fwd0 ? r_fdat0 : w_arr0);
  assign scratch_rdata1  = r_zero1 ? '0 : (r_fwd1 ? r_fdat1 : w_arr1);
  assign scratch_rvalid0 = r_rvalid0;
  assign scratch_rvalid1 = r_rvalid1;
  assign clear_busy      = r_busy;
  assign clear_done      = r_done;

endmodule

// File: tb/tb_scratch_mem_responder.sv
// Scoreboard bench for scratch_mem_responder against an array-level model.
// Follows SCRATCH_MEM_FWD_EN to pick write-first or read-first expectations.
module tb_scratch_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 20;
  localparam int DEPTH = 256;
`ifdef SCRATCH_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          scratch_WE;
  logic [AW-1:0] scratch_write_addr;
  logic [DW-1:0] scratch_wdata;
  logic          scratch_read_en0;
  logic [AW-1:0] scratch_read_addr0;
  logic          scratch_read_en1;
  logic [AW-1:0] scratch_read_addr1;
  logic [DW-1:0] scratch_rdata0;
  logic [DW-1:0] scratch_rdata1;
  logic          scratch_rvalid0;
  logic          scratch_rvalid1;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;

  always #5 clock = ~clock;

  scratch_mem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock              (clock),
    .reset              (reset),
    .scratch_WE         (scratch_WE),
    .scratch_write_addr (scratch_write_addr),
    .scratch_wdata      (scratch_wdata),
    .scratch_read_en0   (scratch_read_en0),
    .scratch_read_addr0 (scratch_read_addr0),
    .scratch_read_en1   (scratch_read_en1),
    .scratch_read_addr1 (scratch_read_addr1),
    .scratch_rdata0     (scratch_rdata0),
    .scratch_rdata1     (scratch_rdata1),
    .scratch_rvalid0    (scratch_rvalid0),
    .scratch_rvalid1    (scratch_rvalid1),
    .clear_start        (clear_start),
    .clear_busy         (clear_busy),
    .clear_done         (clear_done)
  );

  typedef struct {
    bit            known;
    logic [DW-1:0] d;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: array contents, clear progress (-1 idle, 0..255
  // entry being cleared, 256 done cycle), expected response queues.
  logic [DW-1:0] mdata [DEPTH];
  bit            mknown[DEPTH];
  int            clr_pos = -1;
  exp_t          q0[$];
  exp_t          q1[$];
  bit            exp_v0, exp_v1, exp_busy, exp_done;
  exp_t          last0, last1;
  int            nb, nd;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic exp_t lookup(input logic [AW-1:0] ra);
    exp_t e;
    e.known = mknown[ra];
    e.d     = mdata[ra];
    if (clr_pos == -1 && FWD && scratch_WE && ra == scratch_write_addr) begin
      e.known = 1'b1;
      e.d     = scratch_wdata;
    end
    return e;
  endfunction

  task automatic model_edge();
    exp_t e0, e1;
    exp_v0 = scratch_read_en0;
    exp_v1 = scratch_read_en1;
    if (clr_pos >= 0 && clr_pos < DEPTH) begin
      e0.known = 1'b1; e0.d = '0;
      e1.known = 1'b1; e1.d = '0;
      mdata[clr_pos]  = '0;
      mknown[clr_pos] = 1'b1;
      clr_pos++;
    end else if (clr_pos == DEPTH) begin
      e0 = lookup(scratch_read_addr0);
      e1 = lookup(scratch_read_addr1);
      clr_pos = -1;
    end else begin
      e0 = lookup(scratch_read_addr0);
      e1 = lookup(scratch_read_addr1);
      if (scratch_WE) begin
        mdata[scratch_write_addr]  = scratch_wdata;
        mknown[scratch_write_addr] = 1'b1;
      end
      if (clear_start) clr_pos = 0;
    end
    if (scratch_read_en0) q0.push_back(e0);
    if (scratch_read_en1) q1.push_back(e1);
    exp_busy = (clr_pos >= 0 && clr_pos < DEPTH);
    exp_done = (clr_pos == DEPTH);
  endtask

  // Monitor: compares DUT outputs each falling edge.
  always @(negedge clock) begin
    exp_t e;
    chk("clear_busy", 32'(clear_busy), 32'(exp_busy));
    chk("clear_done", 32'(clear_done), 32'(exp_done));
    chk("rvalid0", 32'(scratch_rvalid0), 32'(exp_v0));
    chk("rvalid1", 32'(scratch_rvalid1), 32'(exp_v1));
    if (clear_busy) nb++;
    if (clear_done) nd++;
    if (scratch_rvalid0) begin
      if (q0.size() == 0) chk("rdata0_unexpected", 32'(1), 32'(0));
      else begin
        e = q0.pop_front();
        if (e.known) chk("rdata0", 32'(scratch_rdata0), 32'(e.d));
        last0 = e;
      end
    end else if (last0.known) chk("rdata0_hold", 32'(scratch_rdata0), 32'(last0.d));
    if (scratch_rvalid1) begin
      if (q1.size() == 0) chk("rdata1_unexpected", 32'(1), 32'(0));
      else begin
        e = q1.pop_front();
        if (e.known) chk("rdata1", 32'(scratch_rdata1), 32'(e.d));
        last1 = e;
      end
    end else if (last1.known) chk("rdata1_hold", 32'(scratch_rdata1), 32'(last1.d));
  end

  task automatic idle();
    scratch_WE         = 1'b0;
    scratch_write_addr = '0;
    scratch_wdata      = '0;
    scratch_read_en0   = 1'b0;
    scratch_read_addr0 = '0;
    scratch_read_en1   = 1'b0;
    scratch_read_addr1 = '0;
    clear_start        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_edge();
    @(negedge clock);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    idle();
    scratch_WE         = 1'b1;
    scratch_write_addr = AW'(a);
    scratch_wdata      = DW'(d);
    tick();
  endtask

  task automatic rd2(input int a0, input int a1);
    idle();
    scratch_read_en0   = 1'b1;
    scratch_read_addr0 = AW'(a0);
    scratch_read_en1   = 1'b1;
    scratch_read_addr1 = AW'(a1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(clear_busy), 32'(0));
    chk("rst_done", 32'(clear_done), 32'(0));
    chk("rst_rvalid0", 32'(scratch_rvalid0), 32'(0));
    chk("rst_rvalid1", 32'(scratch_rvalid1), 32'(0));
    chk("rst_rdata0", 32'(scratch_rdata0), 32'(0));
    chk("rst_rdata1", 32'(scratch_rdata1), 32'(0));
    q0.delete();
    q1.delete();
    exp_v0 = 1'b0; exp_v1 = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0;
    last0.known = 1'b1; last0.d = '0;
    last1.known = 1'b1; last1.d = '0;
    clr_pos = -1;
    for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    last0.known = 1'b1; last0.d = '0;
    last1.known = 1'b1; last1.d = '0;
    for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;
    idle();
    #2;
    do_reset();

    // Read-after-write in the next cycle.
    wr(5, 'h00123);
    idle();
    scratch_read_en0   = 1'b1;
    scratch_read_addr0 = AW'(5);
    tick();
    idle();
    tick();

    // Same-cycle write and dual read of one address.
    wr(9, 3);
    idle();
    scratch_WE = 1'b1; scratch_write_addr = AW'(9); scratch_wdata = DW'(7);
    scratch_read_en0 = 1'b1; scratch_read_addr0 = AW'(9);
    scratch_read_en1 = 1'b1; scratch_read_addr1 = AW'(9);
    tick();
    rd2(9, 9);

    // Full clear with writes, reads and a re-trigger while busy.
    wr(0, 'hFFFFF); wr(128, 'hFFFFF); wr(255, 'hFFFFF); wr(10, 'h99);
    idle();
    clear_start = 1'b1;
    scratch_WE = 1'b1; scratch_write_addr = AW'(20); scratch_wdata = DW'('hABC);
    nb = 0; nd = 0;
    tick();
    for (int i = 0; i < 300; i++) begin
      idle();
      if (i == 5) begin
        scratch_WE = 1'b1; scratch_write_addr = AW'(10); scratch_wdata = DW'('h55);
      end
      if (i == 50 || i == 256) clear_start = 1'b1;
      if (i == 7) begin
        scratch_read_en0 = 1'b1; scratch_read_addr0 = AW'(10);
        scratch_read_en1 = 1'b1; scratch_read_addr1 = AW'(128);
      end else if ($urandom_range(0, 3) == 0) begin
        scratch_read_en0 = 1'b1; scratch_read_addr0 = AW'($urandom_range(0, 255));
        scratch_read_en1 = ($urandom_range(0, 1) == 1);
        scratch_read_addr1 = AW'($urandom_range(0, 255));
      end
      tick();
    end
    chk("clear_busy_cycles", 32'(nb), 32'(256));
    chk("clear_done_pulses", 32'(nd), 32'(1));
    rd2(0, 128);
    rd2(255, 10);
    rd2(20, 20);

    // Random traffic on a narrow address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      idle();
      scratch_WE         = ($urandom_range(0, 1) == 1);
      scratch_write_addr = AW'($urandom_range(0, 15));
      scratch_wdata      = DW'($urandom);
      scratch_read_en0   = ($urandom_range(0, 1) == 1);
      scratch_read_addr0 = ($urandom_range(0, 2) == 0) ? scratch_write_addr
                                                       : AW'($urandom_range(0, 15));
      scratch_read_en1   = ($urandom_range(0, 1) == 1);
      scratch_read_addr1 = ($urandom_range(0, 2) == 0) ? scratch_write_addr
                                                       : AW'($urandom_range(0, 15));
      tick();
    end

    // Fill every bin, then stream alternating-port reads.
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 'hFFFFF)));
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      if (i % 2 == 0) begin
        scratch_read_en0 = 1'b1; scratch_read_addr0 = AW'(i);
      end else begin
        scratch_read_en1 = 1'b1; scratch_read_addr1 = AW'(i);
      end
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a clear, then a clean clear afterwards.
    idle();
    clear_start = 1'b1;
    nb = 0; nd = 0;
    tick();
    idle();
    for (int i = 0; i < 99; i++) tick();
    chk("busy_before_reset", 32'(nb), 32'(100));
    do_reset();
    chk("no_done_after_reset", 32'(nd), 32'(0));
    idle();
    clear_start = 1'b1;
    nb = 0; nd = 0;
    tick();
    idle();
    for (int i = 0; i < 270; i++) tick();
    chk("reclear_busy_cycles", 32'(nb), 32'(256));
    chk("reclear_done_pulses", 32'(nd), 32'(1));
    rd2(3, 200);
    rd2(99, 255);
    idle();
    tick();

    chk("q0_drained", 32'(q0.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
